// File: rtl/symbol_packer_if.sv
// Handshake bundle between the symbol source/sink and symbol_packer.
// parity_out exists only when SYMBOL_PACKER_PARITY_EN is defined.
interface symbol_packer_if #(
    parameter int WORD_W = 8
);
    logic [1:0]        data_in;
    logic              valid_in;
    logic              ready_out;
    logic              flush;
    logic [WORD_W-1:0] data_out;
    logic              valid_out;
    logic              ready_in;
    logic [5:0]        word_count;
`ifdef SYMBOL_PACKER_PARITY_EN
    logic              parity_out;

    modport master (
        output data_in, valid_in, flush, ready_in,
        input  ready_out, data_out, valid_out, word_count, parity_out
    );

    modport slave (
        input  data_in, valid_in, flush, ready_in,
        output ready_out, data_out, valid_out, word_count, parity_out
    );
`else
    modport master (
        output data_in, valid_in, flush, ready_in,
        input  ready_out, data_out, valid_out, word_count
    );

    modport slave (
        input  data_in, valid_in, flush, ready_in,
        output ready_out, data_out, valid_out, word_count
    );
`endif
endinterface

// File: rtl/symbol_packer.sv
// Packs 2-bit symbols (first symbol in the MSBs) into words held in a 2-entry FIFO.
// Defining SYMBOL_PACKER_PARITY_EN adds a per-word even-parity bit alongside data_out.
module symbol_packer #(
    parameter int SYM_PER_WORD = 4
) (
    input  logic          clk,
    input  logic          reset,
    symbol_packer_if.slave bus
);
    localparam int WORD_W = 2 * SYM_PER_WORD;
    localparam int IDX_W  = (SYM_PER_WORD > 2) ? $clog2(SYM_PER_WORD) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SYM_PER_WORD - 1);

    logic [WORD_W-3:0] asm_word;
    logic [WORD_W-1:0] new_word;
    logic [WORD_W-1:0] head_word;
    logic [WORD_W-1:0] tail_word;
    logic [IDX_W-1:0]  sym_idx;
    logic [1:0]        fifo_cnt;
    logic [5:0]        pop_count;
    logic              at_last;
    logic              ready;
    logic              accept;
    logic              push;
    logic              pop;
    logic              head_load;
    logic              head_from_tail;
    logic              tail_load;

    // ready depends only on internal state, so a full FIFO holds off the last symbol even if a pop is pending
    always_comb begin
        at_last        = (sym_idx == LAST_IDX);
        ready          = !at_last || (fifo_cnt < 2'd2);
        accept         = bus.valid_in && ready;
        push           = accept && at_last && !bus.flush;
        pop            = (fifo_cnt != 2'd0) && bus.ready_in;
        new_word       = {asm_word, bus.data_in};
        head_from_tail = pop && (fifo_cnt == 2'd2);
        head_load      = (push && (pop || (fifo_cnt == 2'd0))) || head_from_tail;
        tail_load      = push && !pop && (fifo_cnt == 2'd1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sym_idx  <= '0;
            asm_word <= '0;
        end else if (bus.flush) begin
            sym_idx  <= '0;
            asm_word <= '0;
        end else if (accept) begin
            if (at_last) begin
                sym_idx <= '0;
            end else begin
                sym_idx  <= sym_idx + 1'b1;
                asm_word <= new_word[WORD_W-3:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_word <= '0;
            tail_word <= '0;
            fifo_cnt  <= 2'd0;
            pop_count <= 6'd0;
        end else begin
            if (head_load) begin
                head_word <= head_from_tail ? tail_word : new_word;
            end
            if (tail_load) begin
                tail_word <= new_word;
            end
            if (push && !pop) begin
                fifo_cnt <= fifo_cnt + 2'd1;
            end else if (pop && !push) begin
                fifo_cnt <= fifo_cnt - 2'd1;
            end
            if (pop) begin
                pop_count <= pop_count + 6'd1;
            end
        end
    end

`ifdef SYMBOL_PACKER_PARITY_EN
    logic head_par;
    logic tail_par;

    // Parity follows the same load paths as the data words it belongs to
    always_ff @(posedge clk) begin
        if (reset) begin
            head_par <= 1'b0;
            tail_par <= 1'b0;
        end else begin
            if (head_load) begin
                head_par <= head_from_tail ? tail_par : ^new_word;
            end
            if (tail_load) begin
                tail_par <= ^new_word;
            end
        end
    end

    assign bus.parity_out = head_par;
`endif

    assign bus.ready_out  = ready;
    assign bus.data_out   = head_word;
    assign bus.valid_out  = (fifo_cnt != 2'd0);
    assign bus.word_count = pop_count;
endmodule
